// File: rtl/uart_echo_probe.sv
// Purpose : swap-case echo initiator; sends a character sweep over a uart client port and scores the replies.
// Latency : per byte one wr handshake, then the echo or TIMEOUT cycles, plus CHECK and NEXT cycles; status is registered.
// Backpress: waits for busy=0 before each request, holds wr until busy=1; every received byte gets a one-cycle rd.
module uart_echo_probe #(
  parameter int         N_BYTES    = 64,
  parameter logic [7:0] FIRST_CHAR = 8'h20,
  parameter logic [7:0] LAST_CHAR  = 8'h7E,
  parameter int         TIMEOUT    = 50_000,
  parameter int         CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [7:0]       tx_data,
  output logic             wr,
  input  logic             busy,
  input  logic [7:0]       rx_data,
  output logic             rd,
  input  logic             valid,
  input  logic             line_break,   // uart line-break detected ("break" is a reserved word)
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             aborted,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] tout_cnt,
  output logic [7:0]       last_rcvd
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_ACC, S_WAIT_ECHO, S_CHECK, S_NEXT, S_DONE
  } state_t;

  localparam int               TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    T_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_BYTES);

  state_t           state_q, state_d;
  logic [7:0]       chr_q, chr_d, echo_q, echo_d, last_q, last_d;
  logic [CNT_W-1:0] n_q, n_d, err_q, err_d, tout_q, tout_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             wr_q, wr_d, rd_q, rd_d, got_q, got_d;
  logic             run_q, run_d, done_q, done_d, pass_q, pass_d, abort_q, abort_d;
  logic             ack, in_run, echo_cap, t_exp, have_echo;

  function automatic logic [7:0] swap_case(input logic [7:0] c);
    if ((c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A)) return c ^ 8'h20;
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, handshake and status computation
  always_comb begin
    state_d = state_q;
    chr_d   = chr_q;
    echo_d  = echo_q;
    last_d  = last_q;
    n_d     = n_q;
    err_d   = err_q;
    tout_d  = tout_q;
    timer_d = timer_q;
    wr_d    = wr_q;
    got_d   = got_q;
    abort_d = abort_q;

    in_run    = (state_q == S_SEND) || (state_q == S_WAIT_ACC) || (state_q == S_WAIT_ECHO) ||
                (state_q == S_CHECK) || (state_q == S_NEXT);
    // A byte is acknowledged once per valid assertion: rd_q blocks a second ack.
    ack       = valid && !rd_q;
    rd_d      = ack;
    echo_cap  = ack && !got_q && ((state_q == S_WAIT_ACC) || (state_q == S_WAIT_ECHO));
    have_echo = got_q || echo_cap;
    t_exp     = (timer_q == T_LAST);

    if (ack) last_d = rx_data;
    if (echo_cap) begin
      got_d  = 1'b1;
      echo_d = rx_data;
    end
    if ((state_q == S_WAIT_ACC) || (state_q == S_WAIT_ECHO)) timer_d = timer_q + TW'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SEND;
          chr_d   = FIRST_CHAR;
          n_d     = '0;
          err_d   = '0;
          tout_d  = '0;
          abort_d = 1'b0;
        end
      end
      S_SEND: begin
        got_d = 1'b0;
        if (!busy) begin
          wr_d    = 1'b1;
          timer_d = '0;
          state_d = S_WAIT_ACC;
        end
      end
      S_WAIT_ACC: begin
        // Timer already runs here; an early echo still wins over a timeout.
        if (t_exp && !have_echo) begin
          wr_d    = 1'b0;
          tout_d  = sat_inc(tout_q);
          state_d = S_NEXT;
        end else if (busy) begin
          wr_d    = 1'b0;
          state_d = S_WAIT_ECHO;
        end else if (t_exp) begin
          wr_d    = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_WAIT_ECHO: begin
        if (have_echo) begin
          state_d = S_CHECK;
        end else if (t_exp) begin
          tout_d  = sat_inc(tout_q);
          state_d = S_NEXT;
        end
      end
      S_CHECK: begin
        if (echo_q != swap_case(chr_q)) err_d = sat_inc(err_q);
        state_d = S_NEXT;
      end
      S_NEXT: begin
        n_d     = n_q + CNT_W'(1);
        chr_d   = (chr_q == LAST_CHAR) ? FIRST_CHAR : chr_q + 8'd1;
        state_d = (n_q + CNT_W'(1) == N_LAST) ? S_DONE : S_SEND;
      end
      default: state_d = S_IDLE;
    endcase

    // Line break aborts the run from any active state.
    if (in_run && line_break) begin
      wr_d    = 1'b0;
      abort_d = 1'b1;
      state_d = S_DONE;
    end

    run_d  = (state_d == S_SEND) || (state_d == S_WAIT_ACC) || (state_d == S_WAIT_ECHO) ||
             (state_d == S_CHECK) || (state_d == S_NEXT);
    done_d = (state_d == S_DONE);
    pass_d = done_d && !abort_d && (err_d == '0) && (tout_d == '0);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      chr_q   <= FIRST_CHAR;
      echo_q  <= '0;
      last_q  <= '0;
      n_q     <= '0;
      err_q   <= '0;
      tout_q  <= '0;
      timer_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      got_q   <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chr_q   <= chr_d;
      echo_q  <= echo_d;
      last_q  <= last_d;
      n_q     <= n_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
      timer_q <= timer_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      got_q   <= got_d;
      run_q   <= run_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      abort_q <= abort_d;
    end
  end

  assign tx_data   = chr_q;
  assign wr        = wr_q;
  assign rd        = rd_q;
  assign running   = run_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign aborted   = abort_q;
  assign err_cnt   = err_q;
  assign tout_cnt  = tout_q;
  assign last_rcvd = last_q;

endmodule

// File: tb/tb_uart_echo_probe.sv
// Purpose : scoreboard bench for uart_echo_probe with a behavioural uart/echo responder.
// Latency : responder accepts a byte in one cycle, stays busy 8 cycles, replies 130 cycles later.
// Backpress: responder holds valid until rd is seen; busy can be forced high for a window.
module tb_uart_echo_probe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, busy, valid, line_break;
  logic [7:0] rx_data, tx_data, last_rcvd;
  logic       wr, rd, running, done, pass, aborted;
  logic [7:0] err_cnt, tout_cnt;

  logic       w_start, w_busy, w_valid, w_break;
  logic [7:0] w_rx_data, w_tx_data, w_last, w_err, w_tout;
  logic       w_wr, w_rd, w_running, w_done, w_pass, w_aborted;

  always #5 clk = ~clk;

  uart_echo_probe #(.N_BYTES(64), .FIRST_CHAR(8'h20), .LAST_CHAR(8'h7E), .TIMEOUT(200), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .wr(wr), .busy(busy),
    .rx_data(rx_data), .rd(rd), .valid(valid), .line_break(line_break), .running(running),
    .done(done), .pass(pass), .aborted(aborted), .err_cnt(err_cnt), .tout_cnt(tout_cnt),
    .last_rcvd(last_rcvd));

  uart_echo_probe #(.N_BYTES(5), .FIRST_CHAR(8'h7D), .LAST_CHAR(8'h7E), .TIMEOUT(20), .CNT_W(8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(w_start), .tx_data(w_tx_data), .wr(w_wr), .busy(w_busy),
    .rx_data(w_rx_data), .rd(w_rd), .valid(w_valid), .line_break(w_break), .running(w_running),
    .done(w_done), .pass(w_pass), .aborted(w_aborted), .err_cnt(w_err), .tout_cnt(w_tout),
    .last_rcvd(w_last));

  typedef struct {
    logic [7:0] err;
    logic [7:0] tout;
    logic       pass;
    logic       ab;
    int         nacc;
  } st_t;

  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_w[$];
  st_t        exp_st[$];
  int         rep_due[$];
  logic [7:0] rep_dat[$];
  int         acc_cnt = 0;
  int         w_acc = 0;
  int         drop_idx = -1;
  int         drop_cyc = 0;
  bit         unswap_a = 1'b0;
  int         hold_busy = 0;
  int         rd_pulses = 0;
  bit         wrap_fin = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rd) rd_pulses <= rd_pulses + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] swap(input logic [7:0] c);
    if ((c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A)) return c ^ 8'h20;
    return c;
  endfunction

  // uart transmit side: accept wr, check the byte, schedule the echo
  initial begin
    int tx_left;
    logic [7:0] b;
    busy = 1'b0;
    tx_left = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        busy = 1'b0; tx_left = 0;
      end else if (hold_busy > 0) begin
        busy = 1'b1; hold_busy--;
      end else if (tx_left > 0) begin
        busy = 1'b1; tx_left--;
      end else if (wr) begin
        busy = 1'b1; tx_left = 8;
        b = tx_data;
        if (exp_tx.size() == 0) chk("tx_extra", 32'(b), 32'hFFFF_FFFF);
        else chk("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
        if (acc_cnt == drop_idx) drop_cyc = cyc;
        else begin
          rep_due.push_back(cyc + 130);
          rep_dat.push_back((unswap_a && b == 8'h41) ? b : swap(b));
        end
        acc_cnt++;
      end else begin
        busy = 1'b0;
      end
    end
  end

  // uart receive side: present scheduled bytes, clear valid once rd is seen
  initial begin
    valid = 1'b0;
    rx_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (valid && rd) valid = 1'b0;
      else if (!valid && rep_due.size() > 0 && rep_due[0] <= cyc) begin
        valid = 1'b1;
        rx_data = rep_dat.pop_front();
        void'(rep_due.pop_front());
      end
    end
  end

  // Status monitor: scores each rising edge of done against the queued expectation
  initial begin
    logic done_prev;
    st_t  s;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (exp_st.size() == 0) chk("status_unexpected", 32'(done), 32'h0);
        else begin
          s = exp_st.pop_front();
          chk("err_cnt", 32'(err_cnt), 32'(s.err));
          chk("tout_cnt", 32'(tout_cnt), 32'(s.tout));
          chk("pass", 32'(pass), 32'(s.pass));
          chk("aborted", 32'(aborted), 32'(s.ab));
          chk("bytes_sent", acc_cnt, s.nacc);
        end
      end
      done_prev = done;
    end
  end

  // Wrap instance: no echo ever arrives, busy answers each wr for one cycle
  initial begin
    w_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (w_wr && !w_busy) begin
        w_busy = 1'b1;
        if (exp_w.size() == 0) chk("wrap_tx_extra", 32'(w_tx_data), 32'hFFFF_FFFF);
        else chk("wrap_tx", 32'(w_tx_data), 32'(exp_w.pop_front()));
        w_acc++;
      end else begin
        w_busy = 1'b0;
      end
    end
  end

  initial begin
    int k;
    w_start = 1'b0; w_valid = 1'b0; w_break = 1'b0; w_rx_data = 8'h00;
    wait (rst_n === 1'b1);
    @(posedge clk); #1;
    exp_w = '{8'h7D, 8'h7E, 8'h7D, 8'h7E, 8'h7D};
    w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    k = 0;
    while (!w_done && k < 1000) begin @(negedge clk); k++; end
    chk("wrap_done", 32'(w_done), 32'h1);
    chk("wrap_count", w_acc, 5);
    chk("wrap_tout", 32'(w_tout), 32'd5);
    chk("wrap_err", 32'(w_err), 32'd0);
    chk("wrap_pass", 32'(w_pass), 32'h0);
    wrap_fin = 1'b1;
  end

  task automatic push_run(input logic [7:0] e, input logic [7:0] t, input logic p, input logic a,
                          input int n);
    st_t s;
    s.err = e; s.tout = t; s.pass = p; s.ab = a; s.nacc = n;
    exp_st.push_back(s);
  endtask

  task automatic begin_run();
    exp_tx.delete();
    for (int i = 0; i < 64; i++) exp_tx.push_back(8'h20 + 8'(i));
    acc_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 20000) begin @(negedge clk); k++; end
    chk(name, 32'(done), 32'h1);
  endtask

  task automatic wait_acc(input string name, input int n);
    int k = 0;
    while (acc_cnt < n && k < 20000) begin @(negedge clk); k++; end
    chk(name, acc_cnt, n);
  endtask

  initial begin
    int k, r0;
    bit wr_low;
    rst_n = 1'b0; start = 1'b0; line_break = 1'b0;
    #23;
    chk("rst_wr", 32'(wr), 32'h0);
    chk("rst_rd", 32'(rd), 32'h0);
    chk("rst_status", {28'h0, running, done, pass, aborted}, 32'h0);
    chk("rst_counts", {16'h0, err_cnt, tout_cnt}, 32'h0);
    chk("rst_last", 32'(last_rcvd), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h20);
    chk("rst_wrap_tx_data", 32'(w_tx_data), 32'h7D);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // unsolicited byte while idle: one rd pulse, latched, nothing counted
    repeat (3) @(posedge clk);
    r0 = rd_pulses;
    rep_due.push_back(cyc); rep_dat.push_back(8'h5A);
    repeat (10) @(negedge clk);
    chk("idle_rd_pulses", rd_pulses - r0, 1);
    chk("idle_last", 32'(last_rcvd), 32'h5A);
    chk("idle_counts", {16'h0, err_cnt, tout_cnt}, 32'h0);
    chk("idle_status", {28'h0, running, done, pass, aborted}, 32'h0);

    // ideal responder
    push_run(8'd0, 8'd0, 1'b1, 1'b0, 64);
    begin_run();
    @(negedge clk);
    chk("running", 32'(running), 32'h1);
    wait_done("ideal_done");

    // 'A' echoed unswapped
    unswap_a = 1'b1;
    push_run(8'd1, 8'd0, 1'b0, 1'b0, 64);
    begin_run();
    wait_acc("unswap_reach", 35);
    chk("unswap_last", 32'(last_rcvd), 32'h41);
    chk("unswap_err_mid", 32'(err_cnt), 32'd1);
    wait_done("unswap_done");
    unswap_a = 1'b0;

    // byte 5 dropped: timeout exactly 200 cycles after wr rises
    drop_idx = 5;
    push_run(8'd0, 8'd1, 1'b0, 1'b0, 64);
    begin_run();
    k = 0;
    while (tout_cnt != 8'd1 && k < 5000) begin @(negedge clk); k++; end
    chk("drop_tout_delay", cyc - drop_cyc, 200);
    wait_done("drop_done");
    drop_idx = -1;

    // break during the third byte
    push_run(8'd0, 8'd0, 1'b0, 1'b1, 3);
    begin_run();
    k = 0;
    while (!(wr && acc_cnt == 3) && k < 5000) begin @(negedge clk); k++; end
    chk("brk_reach", acc_cnt, 3);
    line_break = 1'b1;
    @(negedge clk);
    line_break = 1'b0;
    chk("brk_wr", 32'(wr), 32'h0);
    chk("brk_flags", {28'h0, running, done, pass, aborted}, 32'h5);
    repeat (300) @(negedge clk);
    chk("brk_idle_after", 32'(done), 32'h1);

    // rerun with busy held 50 cycles on entering SEND
    hold_busy = 50;
    push_run(8'd0, 8'd0, 1'b1, 1'b0, 64);
    begin_run();
    wr_low = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (wr) wr_low = 1'b0;
    end
    chk("busy_hold_wr_low", 32'(wr_low), 32'h1);
    chk("busy_hold_none_sent", acc_cnt, 0);
    wait_done("rerun_done");

    // asynchronous reset with wr asserted
    begin_run();
    k = 0;
    while (!(wr && acc_cnt >= 3) && k < 5000) begin @(negedge clk); k++; end
    chk("arst_wr_before", 32'(wr), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_wr", 32'(wr), 32'h0);
    chk("arst_status", {28'h0, running, done, pass, aborted}, 32'h0);
    chk("arst_tx_data", 32'(tx_data), 32'h20);
    chk("arst_last", 32'(last_rcvd), 32'h0);

    k = 0;
    while (!wrap_fin && k < 1000) begin @(negedge clk); k++; end
    chk("wrap_finished", 32'(wrap_fin), 32'h1);
    chk("status_queue_empty", exp_st.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
